// File: rtl/s2p_pkg.sv
// Shared types and defaults for the serial-to-parallel framing path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package s2p_pkg;

    // Controller states: hunting for the sync header, or capturing words.
    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_PATTERN_DEF = 8'hA5;
    localparam int         WORD_W_DEF       = 32;
    localparam int         FRAME_WORDS_DEF  = 4;
    localparam int         FIFO_DEPTH_DEF   = 4;

    // A FIFO entry carries the data word plus its end-of-frame flag on top.
    function automatic int entry_w(input int word_w);
        return word_w + 1;
    endfunction

    localparam int ENTRY_W_DEF = entry_w(WORD_W_DEF);

endpackage

// File: rtl/s2p_frame_controller_if.sv
// Serial input, parallel output and status bundle of the framing controller.
// Latency: n/a (wires only).
// Backpressure: P_READY from the consumer gates pops of the head word.
interface s2p_frame_controller_if #(
    parameter int WORD_W = s2p_pkg::WORD_W_DEF
);
    logic              S_IN;
    logic              S_VALID;
    logic              P_READY;
    logic              P_VALID;
    logic [WORD_W-1:0] P_OUT;
    logic              P_LAST;
    logic              LOCKED;
    logic              PAR_ERR;
    logic              OVERFLOW;
    logic [7:0]        FRAME_CNT;

    // Environment side: line receiver plus parallel consumer.
    modport master (
        output S_IN, S_VALID, P_READY,
        input  P_VALID, P_OUT, P_LAST, LOCKED, PAR_ERR, OVERFLOW, FRAME_CNT
    );

    // Controller side.
    modport slave (
        input  S_IN, S_VALID, P_READY,
        output P_VALID, P_OUT, P_LAST, LOCKED, PAR_ERR, OVERFLOW, FRAME_CNT
    );
endinterface

// File: rtl/s2p_word_fifo.sv
// Small synchronous fall-through FIFO holding captured words with their last flag.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push on full is ignored unless a pop happens in the same cycle.
module s2p_word_fifo #(
    parameter int W     = s2p_pkg::ENTRY_W_DEF,
    parameter int DEPTH = s2p_pkg::FIFO_DEPTH_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop,
    output logic [W-1:0] o_head_dat,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_wr_en;
    logic         w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees the head slot this cycle, so a push on full is still safe then.
    assign w_wr_en = i_push && (!o_full || i_pop);
    assign w_rd_en = i_pop && !o_empty;

    // Head is forced to zero while empty so the output is clean out of reset.
    assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/s2p_frame_controller.sv
// Hunts the serial stream for a sync header, captures parity-checked words of a frame, buffers them.
// Latency: word visible on P_OUT the cycle after the edge that samples its parity bit.
// Backpressure: P_READY stalls the FIFO head; words arriving on a full FIFO are dropped and flagged.
module s2p_frame_controller
    import s2p_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int         WORD_W       = WORD_W_DEF,
    parameter int         FRAME_WORDS  = FRAME_WORDS_DEF,
    parameter int         FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    s2p_frame_controller_if.slave bus
);
    localparam int EW        = entry_w(WORD_W);
    localparam int BIT_IDX_W = $clog2(WORD_W + 1);

    state_t               r_state;
    logic [7:0]           r_window;
    logic [WORD_W-1:0]    r_shift;
    logic [BIT_IDX_W-1:0] r_bit_idx;
    logic [7:0]           r_word_idx;
    logic                 r_par;
    logic                 r_locked;
    logic                 r_par_err;
    logic                 r_overflow;
    logic [7:0]           r_frame_cnt;

    logic [7:0]           w_window_nxt;
    logic                 w_par_slot;
    logic                 w_par_ok;
    logic                 w_last;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_push_ok;
    logic                 w_drop;
    logic [EW-1:0]        w_push_dat;
    logic [EW-1:0]        w_head_dat;
    logic                 w_full;
    logic                 w_empty;

    assign w_window_nxt = {r_window[6:0], bus.S_IN};

    // The bit after the WORD_W data bits is the parity bit; it closes the word.
    assign w_par_slot = (r_state == ST_CAPTURE) && bus.S_VALID &&
                        (r_bit_idx == BIT_IDX_W'(WORD_W));
    assign w_par_ok   = ~(r_par ^ bus.S_IN);
    assign w_last     = (r_word_idx == 8'(FRAME_WORDS - 1));
    assign w_push     = w_par_slot && w_par_ok;
    assign w_push_dat = {w_last, r_shift};

    assign w_pop      = !w_empty && bus.P_READY;
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;

    s2p_word_fifo #(
        .W     (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    // Framing FSM: sync hunt, bit/word sequencing, parity accumulation and error pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= ST_HUNT;
            r_window   <= '0;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_word_idx <= '0;
            r_par      <= 1'b0;
            r_locked   <= 1'b0;
            r_par_err  <= 1'b0;
        end else begin
            r_par_err <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (bus.S_VALID) begin
                        if (w_window_nxt == SYNC_PATTERN) begin
                            r_state    <= ST_CAPTURE;
                            r_locked   <= 1'b1;
                            r_window   <= '0;
                            r_bit_idx  <= '0;
                            r_word_idx <= '0;
                            r_par      <= 1'b0;
                        end else begin
                            r_window <= w_window_nxt;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.S_VALID) begin
                        if (r_bit_idx != BIT_IDX_W'(WORD_W)) begin
                            r_shift   <= {r_shift[WORD_W-2:0], bus.S_IN};
                            r_par     <= r_par ^ bus.S_IN;
                            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
                        end else begin
                            r_bit_idx <= '0;
                            r_par     <= 1'b0;
                            if (!w_par_ok) begin
                                r_par_err <= 1'b1;
                                r_state   <= ST_HUNT;
                                r_locked  <= 1'b0;
                            end else if (w_last) begin
                                r_state  <= ST_HUNT;
                                r_locked <= 1'b0;
                            end else begin
                                r_word_idx <= r_word_idx + 8'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= ST_HUNT;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flag and count of frames whose last word made it into the FIFO.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overflow  <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_drop) r_overflow <= 1'b1;
            if (w_push_ok && w_last) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign bus.P_VALID   = !w_empty;
    assign bus.P_OUT     = w_head_dat[WORD_W-1:0];
    assign bus.P_LAST    = w_head_dat[WORD_W];
    assign bus.LOCKED    = r_locked;
    assign bus.PAR_ERR   = r_par_err;
    assign bus.OVERFLOW  = r_overflow;
    assign bus.FRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_s2p_frame_controller.sv
module tb_s2p_frame_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] exp_q[$];

    s2p_frame_controller_if #(.WORD_W(32)) bus ();

    s2p_frame_controller dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    // Scoreboard: every accepted head word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.P_VALID && bus.P_READY) begin
            logic [32:0] e;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL unexpected_word: observed %h expected none", {bus.P_LAST, bus.P_OUT});
            end else begin
                e = exp_q.pop_front();
                assert ({bus.P_LAST, bus.P_OUT} === e) else begin
                    n_fail++;
                    $error("FAIL word_out: observed %h expected %h", {bus.P_LAST, bus.P_OUT}, e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int gap);
        bus.S_VALID = 1'b0;
        repeat (gap) begin
            bus.S_IN = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        bus.S_IN    = b;
        bus.S_VALID = 1'b1;
        @(posedge clk); #1;
        idle(gap);
    endtask

    task automatic send_sync(input int gap);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            send_bit(s[i], 0);
            if (i == 1) chk("locked_before_last_sync_bit", 64'(bus.LOCKED), 64'd0);
            if (i == 0) chk("locked_after_sync", 64'(bus.LOCKED), 64'd1);
            idle(gap);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit last, input bit flip,
                             input bit exp_push, input int gap, input bit chk_lat);
        for (int i = 31; i >= 0; i--) send_bit(w[i], gap);
        if (exp_push && !flip) exp_q.push_back({last, w});
        bus.S_IN    = (^w) ^ flip;
        bus.S_VALID = 1'b1;
        @(posedge clk); #1;
        bus.S_VALID = 1'b0;
        if (chk_lat) begin
            chk("p_valid_latency", 64'(bus.P_VALID), 64'(!flip));
            chk("par_err_pulse", 64'(bus.PAR_ERR), 64'(flip));
        end
        idle(gap);
    endtask

    task automatic send_frame(input logic [31:0] ws [4], input bit exp_push,
                              input int gap, input bit chk_lat);
        send_sync(gap);
        for (int i = 0; i < 4; i++) send_word(ws[i], i == 3, 1'b0, exp_push, gap, chk_lat);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && !bus.P_VALID) break;
            @(posedge clk); #1;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_p_valid", 64'(bus.P_VALID), 64'd0);
    endtask

    initial begin
        logic [31:0] f1 [4];
        logic [31:0] f2 [4];
        logic [31:0] f3 [4];
        logic [31:0] f4 [4];
        logic [23:0] noise;
        logic [11:0] ovl;

        f1 = '{32'h12345678, 32'hDEADBEEF, 32'h00000001, 32'hFFFFFFFF};
        f2 = '{32'h0BADF00D, 32'h80000000, 32'h55AA55AA, 32'h7FFFFFFE};
        f3 = '{32'hA5A5A5A5, 32'h00000000, 32'hC0FFEE00, 32'h13579BDF};
        f4 = '{32'hFEEDFACE, 32'h01020304, 32'hF0F0F0F0, 32'h00000003};

        bus.S_IN    = 1'b0;
        bus.S_VALID = 1'b0;
        bus.P_READY = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p_valid",   64'(bus.P_VALID),   64'd0);
        chk("rst_p_out",     64'(bus.P_OUT),     64'd0);
        chk("rst_p_last",    64'(bus.P_LAST),    64'd0);
        chk("rst_locked",    64'(bus.LOCKED),    64'd0);
        chk("rst_par_err",   64'(bus.PAR_ERR),   64'd0);
        chk("rst_overflow",  64'(bus.OVERFLOW),  64'd0);
        chk("rst_frame_cnt", 64'(bus.FRAME_CNT), 64'd0);
        rst = 1'b0;
        idle(2);

        // Basic frame with consumer always ready
        bus.P_READY = 1'b1;
        send_frame(f1, 1'b1, 0, 1'b1);
        chk("locked_after_frame", 64'(bus.LOCKED), 64'd0);
        chk("frame_cnt_1", 64'(bus.FRAME_CNT), 64'd1);
        wait_drain();

        // Noise then near-miss header: lock only on the full header
        noise = {8'h5A, 8'hA4, 8'hA5};
        for (int i = 23; i >= 0; i--) begin
            send_bit(noise[i], 0);
            chk("hunt_noise_locked", 64'(bus.LOCKED), 64'(i == 0));
        end

        // Second word with bad parity aborts the frame
        send_word(32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        send_word(32'h13572468, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        chk("locked_after_par_err", 64'(bus.LOCKED), 64'd0);
        @(posedge clk); #1;
        chk("par_err_single_cycle", 64'(bus.PAR_ERR), 64'd0);
        chk("frame_cnt_after_par_err", 64'(bus.FRAME_CNT), 64'd1);
        wait_drain();

        // Header overlapping a partial header prefix locks on first match
        ovl = 12'hAA5;
        for (int i = 11; i >= 0; i--) begin
            send_bit(ovl[i], 0);
            chk("hunt_overlap_locked", 64'(bus.LOCKED), 64'(i == 0));
        end
        for (int i = 0; i < 4; i++) send_word(f2[i], i == 3, 1'b0, 1'b1, 0, 1'b1);
        chk("frame_cnt_2", 64'(bus.FRAME_CNT), 64'd2);
        wait_drain();

        // Stalled consumer across two frames: four held, rest dropped
        bus.P_READY = 1'b0;
        send_sync(0);
        send_word(f3[0], 1'b0, 1'b0, 1'b1, 0, 1'b1);
        for (int i = 1; i < 4; i++) send_word(f3[i], i == 3, 1'b0, 1'b1, 0, 1'b0);
        chk("overflow_still_clear", 64'(bus.OVERFLOW), 64'd0);
        chk("frame_cnt_fifo_exactly_full", 64'(bus.FRAME_CNT), 64'd3);
        send_sync(0);
        send_word(f4[0], 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("overflow_set", 64'(bus.OVERFLOW), 64'd1);
        for (int i = 1; i < 4; i++) send_word(f4[i], i == 3, 1'b0, 1'b0, 0, 1'b0);
        chk("stall_head_hold", 64'({bus.P_LAST, bus.P_OUT}), 64'({1'b0, f3[0]}));
        chk("frame_cnt_dropped_last", 64'(bus.FRAME_CNT), 64'd3);
        bus.P_READY = 1'b1;
        wait_drain();
        chk("overflow_sticky", 64'(bus.OVERFLOW), 64'd1);

        // Sparse S_VALID: same words, gaps ignored
        send_frame(f2, 1'b1, 1, 1'b1);
        chk("frame_cnt_sparse", 64'(bus.FRAME_CNT), 64'd4);
        wait_drain();

        // Reset mid-word with two words buffered
        bus.P_READY = 1'b0;
        send_sync(0);
        send_word(f1[0], 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send_word(f1[1], 1'b0, 1'b0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
        chk("pre_reset_p_valid", 64'(bus.P_VALID), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_p_valid",   64'(bus.P_VALID),   64'd0);
        chk("midrst_locked",    64'(bus.LOCKED),    64'd0);
        chk("midrst_frame_cnt", 64'(bus.FRAME_CNT), 64'd0);
        chk("midrst_overflow",  64'(bus.OVERFLOW),  64'd0);
        rst = 1'b0;
        bus.P_READY = 1'b1;
        idle(2);
        send_frame(f4, 1'b1, 0, 1'b1);
        chk("frame_cnt_after_reset", 64'(bus.FRAME_CNT), 64'd1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
